// File: rtl/product_accumulator.sv
// Accumulates a stream of signed 64-bit products into a wide signed sum and hands it off per group.
// Optional SATURATE_EN: clamp the sum on signed overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_WIDTH = 72,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [63:0]          product,
  input  logic                 prod_last,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [CNT_WIDTH-1:0] acc_count,
  output logic                 overflow
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and ready here depends on state only.
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state;

  logic                 accept;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] next_acc;
  logic [CNT_WIDTH-1:0] next_count;

  assign prod_ready = (state != HOLD);
  assign accept     = prod_valid & prod_ready;
  assign prod_ext   = ACC_WIDTH'($signed(product));
  assign sum        = acc_out + prod_ext;
  // Same-sign addends producing a sum of the other sign is a signed overflow.
  assign add_ovf    = (acc_out[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_out[ACC_WIDTH-1]);
  assign next_count = (acc_count == {CNT_WIDTH{1'b1}}) ? acc_count
                                                       : acc_count + CNT_WIDTH'(1);

  always_comb begin
    next_acc = sum;
`ifdef SATURATE_EN
    if (add_ovf) begin
      // A positive accumulator can only overflow upward, a negative one downward.
      if (acc_out[ACC_WIDTH-1] == 1'b0)
        next_acc = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else
        next_acc = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_out   <= next_acc;
            acc_count <= next_count;
            overflow  <= overflow | add_ovf;
            if (prod_last) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end else begin
              state     <= ACCUM;
              acc_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_count <= '0;
            overflow  <= 1'b0;
            acc_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc_out   <= '0;
          acc_count <= '0;
          overflow  <= 1'b0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three instances (default, 64-bit acc, 2-bit count) share one stimulus.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [63:0] product;
  logic        prod_last;
  logic        acc_ready;

  logic        m_ready, m_valid, m_ovf;
  logic [71:0] m_acc;
  logic [7:0]  m_cnt;
  logic        o_ready, o_valid, o_ovf;
  logic [63:0] o_acc;
  logic [7:0]  o_cnt;
  logic        c_ready, c_valid, c_ovf;
  logic [71:0] c_acc;
  logic [1:0]  c_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_WIDTH(72), .CNT_WIDTH(8)) dut_main (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(m_ready), .product(product),
    .prod_last(prod_last), .acc_valid(m_valid), .acc_ready(acc_ready), .acc_out(m_acc),
    .acc_count(m_cnt), .overflow(m_ovf));

  product_accumulator #(.ACC_WIDTH(64), .CNT_WIDTH(8)) dut_ovf (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(o_ready), .product(product),
    .prod_last(prod_last), .acc_valid(o_valid), .acc_ready(acc_ready), .acc_out(o_acc),
    .acc_count(o_cnt), .overflow(o_ovf));

  product_accumulator #(.ACC_WIDTH(72), .CNT_WIDTH(2)) dut_cnt (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(c_ready), .product(product),
    .prod_last(prod_last), .acc_valid(c_valid), .acc_ready(acc_ready), .acc_out(c_acc),
    .acc_count(c_cnt), .overflow(c_ovf));

  // Inputs change on the falling edge; outputs are checked there too, half a cycle from the active edge.
  task automatic send(input logic [63:0] p, input logic last);
    @(negedge clk);
    prod_valid = 1'b1;
    product    = p;
    prod_last  = last;
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    product    = '0;
  endtask

  task automatic handoff();
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; prod_valid = 1'b0; prod_last = 1'b0; product = '0; acc_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (m_acc !== 72'd0 || m_cnt !== 8'd0 || m_valid !== 1'b0 || m_ovf !== 1'b0 || m_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: acc=%0h cnt=%0d valid=%b ovf=%b ready=%b, want 0 0 0 0 1",
               m_acc, m_cnt, m_valid, m_ovf, m_ready);
    end
  endtask

  task automatic test_group();
    acc_ready = 1'b1;  // held high outside HOLD: must be ignored
    send(64'd6, 1'b0);
    send(-64'sd15, 1'b0);
    send(64'd100, 1'b1);
    idle_inputs();
    tests_run++;
    if (m_valid !== 1'b1 || m_acc !== 72'd91 || m_cnt !== 8'd3 || m_ovf !== 1'b0 || m_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL group: valid=%b acc=%0h cnt=%0d ovf=%b ready=%b, want 1 5b 3 0 0",
               m_valid, m_acc, m_cnt, m_ovf, m_ready);
    end
    @(negedge clk);
    acc_ready = 1'b0;
    tests_run++;
    if (m_valid !== 1'b0 || m_acc !== 72'd0 || m_cnt !== 8'd0 || m_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL group_handoff: valid=%b acc=%0h cnt=%0d ready=%b, want 0 0 0 1",
               m_valid, m_acc, m_cnt, m_ready);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    // Keep offering a product during HOLD; it must not be taken.
    @(negedge clk);
    product = 64'd55; prod_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid !== 1'b1 || m_acc !== 72'hFF_FFFF_FFFF_FFFF_FFFF || m_cnt !== 8'd1 || m_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL backpressure_hold: %0d bad cycles, last acc=%0h ready=%b, want acc=ff..ff ready=0",
               bad, m_acc, m_ready);
    end
    prod_valid = 1'b0;
    handoff();
    tests_run++;
    if (m_valid !== 1'b0 || m_acc !== 72'd0 || m_cnt !== 8'd0 || m_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_release: valid=%b acc=%0h cnt=%0d ready=%b, want 0 0 0 1",
               m_valid, m_acc, m_cnt, m_ready);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] exp_pos, exp_neg;
`ifdef SATURATE_EN
    exp_pos = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_neg = 64'h8000_0000_0000_0000;
`else
    exp_pos = 64'h8000_0000_0000_0000;
    exp_neg = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'd1, 1'b1);
    idle_inputs();
    tests_run++;
    if (o_valid !== 1'b1 || o_ovf !== 1'b1 || o_acc !== exp_pos || o_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL overflow_pos: valid=%b ovf=%b acc=%0h cnt=%0d, want 1 1 %0h 2",
               o_valid, o_ovf, o_acc, o_cnt, exp_pos);
    end
    tests_run++;
    if (m_ovf !== 1'b0 || m_acc !== 72'h00_8000_0000_0000_0000) begin
      tests_failed++;
      $display("FAIL overflow_wide: ovf=%b acc=%0h, want 0 008000000000000000", m_ovf, m_acc);
    end
    handoff();
    tests_run++;
    if (o_ovf !== 1'b0 || o_acc !== 64'd0) begin
      tests_failed++;
      $display("FAIL overflow_clear: ovf=%b acc=%0h, want 0 0", o_ovf, o_acc);
    end
    // Negative overflow, then a further add keeps the sticky flag set.
    send(64'h8000_0000_0000_0000, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'd0, 1'b1);
    idle_inputs();
    tests_run++;
    if (o_ovf !== 1'b1 || o_acc !== exp_neg || o_cnt !== 8'd3) begin
      tests_failed++;
      $display("FAIL overflow_neg: ovf=%b acc=%0h cnt=%0d, want 1 %0h 3", o_ovf, o_acc, o_cnt, exp_neg);
    end
    handoff();
  endtask

  task automatic test_count_saturation();
    for (int i = 0; i < 5; i++) send(64'd1, (i == 4));
    idle_inputs();
    tests_run++;
    if (c_cnt !== 2'd3 || c_acc !== 72'd5 || c_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL count_sat: cnt=%0d acc=%0h valid=%b, want 3 5 1", c_cnt, c_acc, c_valid);
    end
    tests_run++;
    if (m_cnt !== 8'd5) begin
      tests_failed++;
      $display("FAIL count_wide: cnt=%0d, want 5", m_cnt);
    end
    handoff();
  endtask

  task automatic test_last_without_valid();
    @(negedge clk);
    prod_last = 1'b1;
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b0 || m_ready !== 1'b1 || m_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL last_no_valid_idle: valid=%b ready=%b cnt=%0d, want 0 1 0", m_valid, m_ready, m_cnt);
    end
    send(64'd3, 1'b0);
    idle_inputs();
    prod_last = 1'b1;
    @(negedge clk);
    prod_last = 1'b0;
    send(64'd4, 1'b1);
    idle_inputs();
    tests_run++;
    if (m_valid !== 1'b1 || m_acc !== 72'd7 || m_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL last_no_valid_accum: valid=%b acc=%0h cnt=%0d, want 1 7 2", m_valid, m_acc, m_cnt);
    end
    handoff();
  endtask

  task automatic test_reset_mid_group();
    send(64'd10, 1'b0);
    send(64'd20, 1'b0);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (m_acc !== 72'd0 || m_cnt !== 8'd0 || m_valid !== 1'b0 || m_ovf !== 1'b0 || m_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid: acc=%0h cnt=%0d valid=%b ovf=%b ready=%b, want 0 0 0 0 1",
               m_acc, m_cnt, m_valid, m_ovf, m_ready);
    end
    send(64'd7, 1'b1);
    idle_inputs();
    tests_run++;
    if (m_valid !== 1'b1 || m_acc !== 72'd7 || m_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL after_reset_group: valid=%b acc=%0h cnt=%0d, want 1 7 1", m_valid, m_acc, m_cnt);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    // Two single-product groups offered continuously: the second waits out HOLD plus the handoff.
    acc_ready = 1'b1;
    send(64'd9, 1'b1);
    @(negedge clk);
    product = 64'd11;
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b0 || m_ready !== 1'b1 || m_acc !== 72'd0) begin
      tests_failed++;
      $display("FAIL b2b_bubble: valid=%b ready=%b acc=%0h, want 0 1 0", m_valid, m_ready, m_acc);
    end
    @(posedge clk);
    idle_inputs();
    acc_ready = 1'b0;
    tests_run++;
    if (m_valid !== 1'b1 || m_acc !== 72'd11 || m_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL b2b_second: valid=%b acc=%0h cnt=%0d, want 1 b 1", m_valid, m_acc, m_cnt);
    end
    handoff();
  endtask

  initial begin
    test_reset();
    test_group();
    test_backpressure();
    test_overflow();
    test_count_saturation();
    test_last_without_valid();
    test_reset_mid_group();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
